axis_bp_scheduler: RTL and testbench
====================================

// Module: axis_bp_scheduler
// PURPOSE
// Sequences the bp_ratio_code input of an AXI4-Stream dummy slave through a
// programmable table of (ratio, duration) phases. The bench or CSR block loads
// the table and pulses start. The scheduler steps through the phases and can
// loop. It also counts the beats accepted on the monitored stream while running.
// It sits between test-control logic and one dummy slave's bp_ratio_code port.
// PARAMETERS
// NUM_PHASES  4   number of table entries (>=1); AW = $clog2(NUM_PHASES), min 1
// CNT_WIDTH   32  width of phase-duration and beat counters
// PORTS
// clk              in   1          clock
// rst_n            in   1          async active-low reset
// cfg_we           in   1          write table entry cfg_addr
// cfg_addr         in   AW         table index; writes with index >= NUM_PHASES are ignored
// cfg_ratio        in   64         ratio code for the entry
// cfg_len          in   CNT_WIDTH  entry duration in cycles (0 treated as 1)
// cfg_num_phases   in   AW+1       active entries 0..NUM_PHASES (larger values clamp)
// loop_en          in   1          1: wrap to phase 0 after the last phase
// start            in   1          pulse: begin a run
// stop             in   1          pulse: abort a run
// mon_tvalid       in   1          monitored s_axis_tvalid
// mon_tready       in   1          monitored s_axis_tready
// bp_ratio_code    out  64         to dummy slave; ready = rand64 >= code
// phase_idx        out  AW         current phase
// busy             out  1          high in RUN
// done             out  1          1-cycle pulse at normal completion
// beat_cnt         out  CNT_WIDTH  accepted beats in current/last run
// BEHAVIOUR
// - Reset values: bp_ratio_code=0 (no backpressure), phase_idx=0, busy=0,
//   done=0, beat_cnt=0. The table resets to ratio=0, len=1.
// - Deasserting rst_n at any time, including mid-run, forces IDLE at once.
// - FSM states: IDLE, RUN, DONE. All outputs are registered.
// - IDLE: bp_ratio_code=0.
//   - start=1, stop=0, num_phases>0: load phase 0, clear beat_cnt, go to RUN.
//   - stop=1: stay in IDLE (stop wins over start).
//   - start with num_phases=0: go to DONE; beat_cnt is cleared.
// - RUN: in the cycle after start, bp_ratio_code=ratio[0], busy=1,
//   phase_idx=0. The phase timer is loaded with max(len,1).
// - The timer decrements each cycle. On the last cycle of a phase (timer==1):
//   - if idx<num_phases-1: advance idx and load the next entry;
//   - else if loop_en: go back to idx 0;
//   - else go to DONE.
// - Each phase therefore holds its code for exactly max(len,1) cycles.
// - stop in RUN: go to IDLE next cycle. There is no done pulse, and beat_cnt
//   holds its value. start while in RUN is ignored.
// - DONE: lasts one cycle with done=1, busy=0, bp_ratio_code=0, then goes to IDLE.
// - beat_cnt increments on cycles where busy && mon_tvalid && mon_tready.
//   It saturates at all-ones and never wraps.
// - cfg writes are accepted in any state. In RUN, a write to an entry takes
//   effect the next time that entry is loaded. A write to the current entry
//   does not change the active code or timer.
// - Changing num_phases or loop_en mid-run is sampled at each phase boundary.
// - The dummy slave adds 2 cycles (code register + ready register). A code
//   change reaches tready 2 cycles after bp_ratio_code changes.
// TESTING
// - Reset: table ratio={0,0x4000..0,0x8000..0,0xC000..0}, len={10,20,5,1},
//   num=4, start -> codes hold 10/20/5/1 cycles. done pulses once at cycle 37
//   after start. Outputs are 0 afterwards.
// - loop_en=1, num=2, len={3,3}: phase_idx follows 0,0,0,1,1,1,0... for 3 laps.
//   Then stop -> busy=0 next cycle, done stays 0, code=0.
// - len=0 entry -> code held 1 cycle. num=0 start -> done pulse only, busy stays 0.
// - mon_tvalid=1 with ready forced high for 50 cycles in RUN -> beat_cnt=50.
//   With CNT_WIDTH=4 it saturates at 15. Beats seen in IDLE are not counted.
// - Write phase 1 while phase 0 runs -> the new value is used. Write the
//   current entry -> no change until the next lap. start and stop together in
//   IDLE -> stays IDLE.
// - Assert rst_n=0 mid-phase 2 -> all outputs 0 immediately. A restart then
//   begins at phase 0.

Source files
------------

// File: rtl/axis_bp_scheduler.sv
// Steps a dummy AXIS slave's bp_ratio_code through a (ratio, duration) phase table, optionally looping, and counts accepted beats.
// Latency: all outputs registered; the first phase code appears the cycle after start. Backpressure: none; a pure sink of control inputs.
module axis_bp_scheduler #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_WIDTH  = 32,
  localparam int AW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [63:0]          cfg_ratio,
  input  logic [CNT_WIDTH-1:0] cfg_len,
  input  logic [AW:0]          cfg_num_phases,
  input  logic                 loop_en,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  output logic [63:0]          bp_ratio_code,
  output logic [AW-1:0]        phase_idx,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] beat_cnt
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] NP = (AW+1)'(NUM_PHASES);
  localparam logic [AW:0] ONE_IDX = (AW+1)'(1);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [63:0]          ratio_tbl [DEPTH];
  logic [CNT_WIDTH-1:0] len_tbl   [DEPTH];
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic [63:0]          code_d;
  logic [AW-1:0]        idx_d;
  logic                 busy_d, done_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [AW:0]          num_c;
  logic [AW:0]          idx_nx;

  function automatic logic [CNT_WIDTH-1:0] len_ld(input logic [CNT_WIDTH-1:0] l);
    return (l == '0) ? ONE_CNT : l;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ratio_tbl[i] <= '0;
        len_tbl[i]   <= ONE_CNT;
      end
    end else if (cfg_we && ({1'b0, cfg_addr} < NP)) begin
      ratio_tbl[cfg_addr] <= cfg_ratio;
      len_tbl[cfg_addr]   <= cfg_len;
    end
  end

  assign num_c  = (cfg_num_phases > NP) ? NP : cfg_num_phases;
  assign idx_nx = {1'b0, phase_idx} + ONE_IDX;

  always_comb begin
    state_d = state_q;
    code_d  = bp_ratio_code;
    idx_d   = phase_idx;
    timer_d = timer_q;
    busy_d  = busy;
    done_d  = 1'b0;
    cnt_d   = beat_cnt;
    if (busy && mon_tvalid && mon_tready && (beat_cnt != '1))
      cnt_d = beat_cnt + ONE_CNT;
    case (state_q)
      IDLE: begin
        code_d = '0;
        busy_d = 1'b0;
        idx_d  = '0;
        if (start && !stop) begin
          cnt_d = '0;
          if (num_c != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
            code_d  = ratio_tbl[0];
            timer_d = len_ld(len_tbl[0]);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          code_d  = '0;
          idx_d   = '0;
        end else if (timer_q == ONE_CNT) begin
          // num_phases and loop_en are only looked at here, on the phase boundary
          if (idx_nx < num_c) begin
            idx_d   = idx_nx[AW-1:0];
            code_d  = ratio_tbl[idx_nx[AW-1:0]];
            timer_d = len_ld(len_tbl[idx_nx[AW-1:0]]);
          end else if (loop_en && (num_c != '0)) begin
            idx_d   = '0;
            code_d  = ratio_tbl[0];
            timer_d = len_ld(len_tbl[0]);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            code_d  = '0;
            idx_d   = '0;
          end
        end else begin
          timer_d = timer_q - ONE_CNT;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        code_d  = '0;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        code_d  = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bp_ratio_code <= '0;
      phase_idx     <= '0;
      timer_q       <= ONE_CNT;
      busy          <= 1'b0;
      done          <= 1'b0;
      beat_cnt      <= '0;
    end else begin
      state_q       <= state_d;
      bp_ratio_code <= code_d;
      phase_idx     <= idx_d;
      timer_q       <= timer_d;
      busy          <= busy_d;
      done          <= done_d;
      beat_cnt      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_bp_scheduler.sv
// Directed bench for axis_bp_scheduler: row tables for phase sequencing plus hand sequences for beats, cfg writes and reset.
module tb_axis_bp_scheduler;

  localparam logic [63:0] R0 = 64'h0;
  localparam logic [63:0] R1 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] R2 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] R3 = 64'hC000_0000_0000_0000;
  localparam logic [63:0] RC = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] RD = 64'h0FED_CBA9_8765_4321;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [63:0] cfg_ratio = '0;
  logic [31:0] cfg_len = '0;
  logic [2:0]  cfg_num_phases = '0;
  logic        loop_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mon_tvalid = 1'b0;
  logic        mon_tready = 1'b0;
  logic [63:0] bp_ratio_code;
  logic [1:0]  phase_idx;
  logic        busy, done;
  logic [31:0] beat_cnt;
  logic [63:0] s_code;
  logic [1:0]  s_idx;
  logic        s_busy, s_done;
  logic [3:0]  s_beat;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        start;
    logic        stop;
    int          n;
    logic [63:0] code;
    logic [1:0]  idx;
    logic        busy;
    logic        done;
  } row_t;
  row_t rows[$];

  always #5 clk = ~clk;

  axis_bp_scheduler #(.NUM_PHASES(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_ratio(cfg_ratio), .cfg_len(cfg_len), .cfg_num_phases(cfg_num_phases),
    .loop_en(loop_en), .start(start), .stop(stop),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .bp_ratio_code(bp_ratio_code), .phase_idx(phase_idx), .busy(busy),
    .done(done), .beat_cnt(beat_cnt)
  );

  axis_bp_scheduler #(.NUM_PHASES(4), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_ratio(cfg_ratio), .cfg_len(cfg_len[3:0]), .cfg_num_phases(cfg_num_phases),
    .loop_en(loop_en), .start(start), .stop(stop),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .bp_ratio_code(s_code), .phase_idx(s_idx), .busy(s_busy),
    .done(s_done), .beat_cnt(s_beat)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [63:0] c, input logic [1:0] i,
                         input logic b, input logic d);
    chk({nm, ".code"}, bp_ratio_code, c);
    chk({nm, ".idx"}, {62'd0, phase_idx}, {62'd0, i});
    chk({nm, ".busy"}, {63'd0, busy}, {63'd0, b});
    chk({nm, ".done"}, {63'd0, done}, {63'd0, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [63:0] r, input logic [31:0] l);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_ratio = r; cfg_len = l;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic add(input logic s, input logic p, input int n, input logic [63:0] c,
                     input logic [1:0] i, input logic b, input logic d);
    row_t r;
    r.start = s; r.stop = p; r.n = n; r.code = c; r.idx = i; r.busy = b; r.done = d;
    rows.push_back(r);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r < hi; r++) begin
      start = rows[r].start;
      stop  = rows[r].stop;
      for (int k = 0; k < rows[r].n; k++) begin
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk_out($sformatf("row%0d.%0d", r, k), rows[r].code, rows[r].idx, rows[r].busy, rows[r].done);
      end
    end
  endtask

  task automatic load_main();
    wr(0, R0, 10); wr(1, R1, 20); wr(2, R2, 5); wr(3, R3, 1);
  endtask

  int t0_lo, t0_hi, t1_lo, t1_hi, t2_lo, t2_hi, t3_lo, t3_hi, t4_lo, t4_hi, t5_lo, t5_hi;

  initial begin
    // reset table contents: ratio 0, len 1 -> one busy cycle then done
    t0_lo = rows.size();
    add(1, 0, 1, R0, 0, 1, 0); add(0, 0, 1, 0, 0, 0, 1); add(0, 0, 2, 0, 0, 0, 0);
    t0_hi = rows.size();
    // 10/20/5/1 cycle phases, done on cycle 37
    t1_lo = rows.size();
    add(1, 0, 1, R0, 0, 1, 0); add(0, 0, 9, R0, 0, 1, 0); add(0, 0, 20, R1, 1, 1, 0);
    add(0, 0, 5, R2, 2, 1, 0); add(0, 0, 1, R3, 3, 1, 0); add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 3, 0, 0, 0, 0);
    t1_hi = rows.size();
    // loop over 2 phases of 3 cycles for 3 laps, then stop
    t2_lo = rows.size();
    add(1, 0, 1, R0, 0, 1, 0); add(0, 0, 2, R0, 0, 1, 0); add(0, 0, 3, R1, 1, 1, 0);
    add(0, 0, 3, R0, 0, 1, 0); add(0, 0, 3, R1, 1, 1, 0); add(0, 0, 3, R0, 0, 1, 0);
    add(0, 0, 3, R1, 1, 1, 0); add(0, 1, 1, 0, 0, 0, 0); add(0, 0, 3, 0, 0, 0, 0);
    t2_hi = rows.size();
    // zero-length middle entry holds one cycle
    t3_lo = rows.size();
    add(1, 0, 2, R1, 0, 1, 0); add(0, 0, 1, R2, 1, 1, 0); add(0, 0, 2, R3, 2, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1); add(0, 0, 1, 0, 0, 0, 0);
    t3_hi = rows.size();
    // num_phases = 0: done pulse only
    t4_lo = rows.size();
    add(1, 0, 1, 0, 0, 0, 1); add(0, 0, 2, 0, 0, 0, 0);
    t4_hi = rows.size();
    // start and stop together in idle
    t5_lo = rows.size();
    add(1, 1, 1, 0, 0, 0, 0); add(0, 0, 2, 0, 0, 0, 0);
    t5_hi = rows.size();

    #1;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.beat", {32'd0, beat_cnt}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    cfg_num_phases = 3'd1;
    run_rows(t0_lo, t0_hi);

    load_main();
    cfg_num_phases = 3'd4;
    run_rows(t1_lo, t1_hi);
    chk("main.beat", {32'd0, beat_cnt}, 64'd0);

    wr(0, R0, 3); wr(1, R1, 3);
    cfg_num_phases = 3'd2; loop_en = 1'b1;
    run_rows(t2_lo, t2_hi);
    loop_en = 1'b0;

    wr(0, R1, 2); wr(1, R2, 0); wr(2, R3, 2);
    cfg_num_phases = 3'd3;
    run_rows(t3_lo, t3_hi);

    cfg_num_phases = 3'd0;
    run_rows(t4_lo, t4_hi);
    cfg_num_phases = 3'd2;
    run_rows(t5_lo, t5_hi);

    // beat counting: 50 accepted beats in RUN, none counted in IDLE
    wr(0, R1, 100);
    cfg_num_phases = 3'd1; loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("beat.busy", {63'd0, busy}, 64'd1);
    mon_tvalid = 1'b1; mon_tready = 1'b1;
    for (int i = 0; i < 50; i++) step();
    mon_tvalid = 1'b0;
    step();
    chk("beat.cnt50", {32'd0, beat_cnt}, 64'd50);
    chk("beat.sat15", {60'd0, s_beat}, 64'd15);
    chk("beat.sat_busy", {63'd0, s_busy}, 64'd1);
    mon_tready = 1'b0; mon_tvalid = 1'b1;
    step(); step();
    chk("beat.notready", {32'd0, beat_cnt}, 64'd50);
    stop = 1'b1; step(); stop = 1'b0;
    chk_out("beat.stop", 0, 0, 0, 0);
    mon_tready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("beat.idle", {32'd0, beat_cnt}, 64'd50);
    mon_tvalid = 1'b0; mon_tready = 1'b0;
    loop_en = 1'b0;

    // mid-run table writes: next entry takes effect, current entry waits a lap
    wr(0, R1, 4); wr(1, R2, 4);
    cfg_num_phases = 3'd2; loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk_out("wr.c1", R1, 0, 1, 0);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_ratio = RC; cfg_len = 32'd4;
    step();
    chk_out("wr.c2", R1, 0, 1, 0);
    cfg_addr = 2'd0; cfg_ratio = RD; cfg_len = 32'd2;
    step();
    cfg_we = 1'b0;
    chk_out("wr.c3", R1, 0, 1, 0);
    step();
    chk_out("wr.c4", R1, 0, 1, 0);
    step();
    chk_out("wr.next", RC, 1, 1, 0);
    step(); step(); step();
    chk_out("wr.next_end", RC, 1, 1, 0);
    step();
    chk_out("wr.lap", RD, 0, 1, 0);
    step();
    chk_out("wr.lap2", RD, 0, 1, 0);
    step();
    chk_out("wr.lap_len", RC, 1, 1, 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk_out("wr.stop", 0, 0, 0, 0);
    loop_en = 1'b0;

    // async reset mid phase 2, then a full restart with clamped num_phases
    load_main();
    cfg_num_phases = 3'd4;
    mon_tvalid = 1'b1; mon_tready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 32; i++) step();
    chk_out("rst.pre", R2, 2, 1, 0);
    rst_n = 1'b0;
    #1;
    chk_out("rst.async", 0, 0, 0, 0);
    chk("rst.beat", {32'd0, beat_cnt}, 64'd0);
    mon_tvalid = 1'b0; mon_tready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    load_main();
    cfg_num_phases = 3'd7;
    run_rows(t1_lo, t1_hi);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
